// File: rtl/alu_seq_muldiv.sv
// alu_seq_muldiv: handshaked EX-stage ALU. Single-cycle logic/arith/shift ops
// plus iterative shift-add multiply and restoring divide into a HI/LO pair.
//
// Build option: define ALU_DIV_EN to include DIV/DIVU; without it, opcodes
// 1010/1011 are reported as illegal like any other unknown opcode.
//
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   in_valid/in_ready request handshake (ready only while idle)
//   alu_control       4-bit opcode
//   read_data_1/2     operands A (rs) and B (rt / imm)
//   shamt             shift amount for SLL/SRL
//   out_valid/out_ready result handshake; result held until accepted
//   alu_result        result, product low half or quotient
//   hi_result         product high half or remainder (0 for 1-cycle ops)
//   zero              alu_result == 0
//   illegal           opcode unsupported
module alu_seq_muldiv #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [3:0]         alu_control,
   input  logic [WIDTH-1:0]   read_data_1,
   input  logic [WIDTH-1:0]   read_data_2,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   alu_result,
   output logic [WIDTH-1:0]   hi_result,
   output logic               zero,
   output logic               illegal
);

   localparam logic [3:0] OP_AND   = 4'b0000;
   localparam logic [3:0] OP_OR    = 4'b0001;
   localparam logic [3:0] OP_ADD   = 4'b0010;
   localparam logic [3:0] OP_SLTU  = 4'b0011;
   localparam logic [3:0] OP_SUB   = 4'b0110;
   localparam logic [3:0] OP_SLT   = 4'b0111;
   localparam logic [3:0] OP_MULT  = 4'b1000;
   localparam logic [3:0] OP_MULTU = 4'b1001;
   localparam logic [3:0] OP_DIV   = 4'b1010;
`ifdef ALU_DIV_EN
   localparam logic [3:0] OP_DIVU  = 4'b1011;
`endif
   localparam logic [3:0] OP_NOR   = 4'b1100;
   localparam logic [3:0] OP_SLL   = 4'b1101;
   localparam logic [3:0] OP_SRL   = 4'b1110;

   typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [SHAMT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0]   acc_hi_q, acc_hi_d;   // partial product high / remainder
   logic [WIDTH-1:0]   acc_lo_q, acc_lo_d;   // multiplier / dividend-quotient
   logic [WIDTH-1:0]   opnd_q, opnd_d;       // multiplicand / divisor magnitude
   logic               neg_res_q, neg_res_d;
`ifdef ALU_DIV_EN
   logic               is_div_q, is_div_d;
   logic               neg_rem_q, neg_rem_d;
`endif
   logic [WIDTH-1:0]   res_q, res_d;
   logic [WIDTH-1:0]   hi_q, hi_d;
   logic               zero_q, zero_d;
   logic               ill_q, ill_d;
   logic               ovld_q, ovld_d;
   logic               irdy_q, irdy_d;

   // Signed ops iterate on magnitudes; the sign is restored on the last step
   logic               sgn_op;
   logic [WIDTH-1:0]   abs_a, abs_b;
   always_comb begin
      sgn_op = (alu_control == OP_MULT) || (alu_control == OP_DIV);
      abs_a  = (sgn_op && read_data_1[WIDTH-1]) ? -read_data_1 : read_data_1;
      abs_b  = (sgn_op && read_data_2[WIDTH-1]) ? -read_data_2 : read_data_2;
   end

   // One shift-add multiply step; product shifts right through {acc_hi, acc_lo}
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH-1:0]   mul_hi_n, mul_lo_n;
   logic [2*WIDTH-1:0] mul_prod;
   always_comb begin
      mul_sum  = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);
      mul_hi_n = mul_sum[WIDTH:1];
      mul_lo_n = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
      mul_prod = neg_res_q ? -{mul_hi_n, mul_lo_n} : {mul_hi_n, mul_lo_n};
   end

`ifdef ALU_DIV_EN
   // One restoring divide step; quotient bits shift in from the right
   logic [WIDTH:0]     div_sh;
   logic [WIDTH-1:0]   div_diff, div_rem_n, div_quo_n;
   logic               div_ge;
   always_comb begin
      div_sh    = {acc_hi_q, acc_lo_q[WIDTH-1]};
      div_ge    = div_sh >= {1'b0, opnd_q};
      div_diff  = div_sh[WIDTH-1:0] - opnd_q;
      div_rem_n = div_ge ? div_diff : div_sh[WIDTH-1:0];
      div_quo_n = {acc_lo_q[WIDTH-2:0], div_ge};
   end
`endif

   // Next-state and result logic
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      acc_hi_d  = acc_hi_q;
      acc_lo_d  = acc_lo_q;
      opnd_d    = opnd_q;
      neg_res_d = neg_res_q;
`ifdef ALU_DIV_EN
      is_div_d  = is_div_q;
      neg_rem_d = neg_rem_q;
`endif
      res_d     = res_q;
      hi_d      = hi_q;
      ill_d     = ill_q;

      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               state_d = S_DONE;
               cnt_d   = '0;
               res_d   = '0;
               hi_d    = '0;
               ill_d   = 1'b0;
               case (alu_control)
                  OP_AND:  res_d = read_data_1 & read_data_2;
                  OP_OR:   res_d = read_data_1 | read_data_2;
                  OP_NOR:  res_d = ~(read_data_1 | read_data_2);
                  OP_ADD:  res_d = read_data_1 + read_data_2;
                  OP_SUB:  res_d = read_data_1 - read_data_2;
                  OP_SLT:  res_d = WIDTH'($signed(read_data_1) < $signed(read_data_2));
                  OP_SLTU: res_d = WIDTH'(read_data_1 < read_data_2);
                  OP_SLL:  res_d = (32'(shamt) >= WIDTH) ? '0 : read_data_2 << shamt;
                  OP_SRL:  res_d = (32'(shamt) >= WIDTH) ? '0 : read_data_2 >> shamt;
                  OP_MULT, OP_MULTU: begin
                     state_d   = S_EXEC;
                     opnd_d    = abs_a;
                     acc_lo_d  = abs_b;
                     acc_hi_d  = '0;
                     neg_res_d = sgn_op & (read_data_1[WIDTH-1] ^ read_data_2[WIDTH-1]);
`ifdef ALU_DIV_EN
                     is_div_d  = 1'b0;
`endif
                  end
`ifdef ALU_DIV_EN
                  OP_DIV, OP_DIVU: begin
                     if (read_data_2 == '0) begin
                        res_d = '1;
                        hi_d  = read_data_1;
                     end else begin
                        state_d   = S_EXEC;
                        opnd_d    = abs_b;
                        acc_lo_d  = abs_a;
                        acc_hi_d  = '0;
                        neg_res_d = sgn_op & (read_data_1[WIDTH-1] ^ read_data_2[WIDTH-1]);
                        neg_rem_d = sgn_op & read_data_1[WIDTH-1];
                        is_div_d  = 1'b1;
                     end
                  end
`endif
                  default: ill_d = 1'b1;
               endcase
            end
         end
         S_EXEC: begin
            cnt_d    = cnt_q + SHAMT_W'(1);
            acc_hi_d = mul_hi_n;
            acc_lo_d = mul_lo_n;
`ifdef ALU_DIV_EN
            if (is_div_q) begin
               acc_hi_d = div_rem_n;
               acc_lo_d = div_quo_n;
            end
`endif
            if (cnt_q == SHAMT_W'(WIDTH-1)) begin
               state_d       = S_DONE;
               {hi_d, res_d} = mul_prod;
`ifdef ALU_DIV_EN
               if (is_div_q) begin
                  res_d = neg_res_q ? -div_quo_n : div_quo_n;
                  hi_d  = neg_rem_q ? -div_rem_n : div_rem_n;
               end
`endif
            end
         end
         S_DONE: begin
            if (out_ready) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      zero_d = (res_d == '0);
      ovld_d = (state_d == S_DONE);
      irdy_d = (state_d == S_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         acc_hi_q  <= '0;
         acc_lo_q  <= '0;
         opnd_q    <= '0;
         neg_res_q <= 1'b0;
`ifdef ALU_DIV_EN
         is_div_q  <= 1'b0;
         neg_rem_q <= 1'b0;
`endif
         res_q     <= '0;
         hi_q      <= '0;
         zero_q    <= 1'b1;
         ill_q     <= 1'b0;
         ovld_q    <= 1'b0;
         irdy_q    <= 1'b1;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         acc_hi_q  <= acc_hi_d;
         acc_lo_q  <= acc_lo_d;
         opnd_q    <= opnd_d;
         neg_res_q <= neg_res_d;
`ifdef ALU_DIV_EN
         is_div_q  <= is_div_d;
         neg_rem_q <= neg_rem_d;
`endif
         res_q     <= res_d;
         hi_q      <= hi_d;
         zero_q    <= zero_d;
         ill_q     <= ill_d;
         ovld_q    <= ovld_d;
         irdy_q    <= irdy_d;
      end
   end

   assign in_ready   = irdy_q;
   assign out_valid  = ovld_q;
   assign alu_result = res_q;
   assign hi_result  = hi_q;
   assign zero       = zero_q;
   assign illegal    = ill_q;

endmodule
